// File: rtl/axi_rw_arbiter.sv
// Round-robin arbiter between an instruction-fetch master (read-only) and a load/store master,
// presenting one registered request at a time to the AXI read/write bridge.
module axi_rw_arbiter #(
  parameter int unsigned RW_DATA_WIDTH = 64,
  parameter int unsigned RW_ADDR_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0] if_addr_i,
  output logic [RW_DATA_WIDTH-1:0] if_data_o,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic                     mem_we_i,
  input  logic [RW_ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [RW_DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [7:0]               mem_strb_i,
  output logic [RW_DATA_WIDTH-1:0] mem_data_o,
  output logic                     rw_valid_o,
  input  logic                     rw_ready_i,
  output logic                     rw_we_o,
  output logic [RW_ADDR_WIDTH-1:0] rw_addr_o,
  output logic [RW_DATA_WIDTH-1:0] rw_w_data_o,
  output logic [7:0]               rw_size_o,
  input  logic [RW_DATA_WIDTH-1:0] rw_data_i
);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntMem, StResp} state_e;

  state_e                   state_q, state_d;
  logic                     last_mem_q, last_mem_d;
  logic                     resp_mem_q, resp_mem_d;
  logic                     we_q, we_d;
  logic [RW_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RW_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]               size_q, size_d;
  logic [RW_DATA_WIDTH-1:0] if_data_q, if_data_d;
  logic [RW_DATA_WIDTH-1:0] mem_data_q, mem_data_d;

  always_comb begin
    state_d    = state_q;
    last_mem_d = last_mem_q;
    resp_mem_d = resp_mem_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      StIdle: begin
        // On a tie, IF wins only if MEM was granted last.
        if (if_valid_i && (!mem_valid_i || last_mem_q)) begin
          state_d    = StGntIf;
          last_mem_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = if_addr_i;
          wdata_d    = '0;
          size_d     = 8'hFF;
        end else if (mem_valid_i) begin
          state_d    = StGntMem;
          last_mem_d = 1'b1;
          we_d       = mem_we_i;
          addr_d     = mem_addr_i;
          wdata_d    = mem_wdata_i;
          size_d     = mem_strb_i;
        end
      end
      StGntIf: begin
        if (rw_ready_i) begin
          if_data_d  = rw_data_i;
          resp_mem_d = 1'b0;
          state_d    = StResp;
        end
      end
      StGntMem: begin
        if (rw_ready_i) begin
          mem_data_d = rw_data_i;
          resp_mem_d = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_mem_q <= 1'b0;
      resp_mem_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_mem_q <= last_mem_d;
      resp_mem_q <= resp_mem_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    rw_valid_o  = (state_q == StGntIf) || (state_q == StGntMem);
    if_ready_o  = (state_q == StResp) && !resp_mem_q;
    mem_ready_o = (state_q == StResp) && resp_mem_q;
    rw_we_o     = we_q;
    rw_addr_o   = addr_q;
    rw_w_data_o = wdata_q;
    rw_size_o   = size_q;
    if_data_o   = if_data_q;
    mem_data_o  = mem_data_q;
  end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed bench for axi_rw_arbiter: a bridge model answers grants, expected responses go through
// a scoreboard queue that a monitor drains on every ready pulse.
module tb_axi_rw_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid_i = 1'b0;
  logic        if_ready_o;
  logic [31:0] if_addr_i = '0;
  logic [63:0] if_data_o;
  logic        mem_valid_i = 1'b0;
  logic        mem_ready_o;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [63:0] mem_wdata_i = '0;
  logic [7:0]  mem_strb_i = '0;
  logic [63:0] mem_data_o;
  logic        rw_valid_o;
  logic        rw_ready_i = 1'b0;
  logic        rw_we_o;
  logic [31:0] rw_addr_o;
  logic [63:0] rw_w_data_o;
  logic [7:0]  rw_size_o;
  logic [63:0] rw_data_i = '0;

  axi_rw_arbiter #(.RW_DATA_WIDTH(64), .RW_ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
    .mem_data_o(mem_data_o),
    .rw_valid_o(rw_valid_o), .rw_ready_i(rw_ready_i), .rw_we_o(rw_we_o),
    .rw_addr_o(rw_addr_o), .rw_w_data_o(rw_w_data_o), .rw_size_o(rw_size_o),
    .rw_data_i(rw_data_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          m;
    logic [63:0] d;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   if_pulses = 0;
  int   mem_pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every ready pulse must match the oldest expected response.
  always @(negedge clock) begin
    if (reset && (if_ready_o || mem_ready_o)) begin
      if (if_ready_o) if_pulses++;
      if (mem_ready_o) mem_pulses++;
      check("single_ready", {63'd0, if_ready_o & mem_ready_o}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_ready", {62'd0, if_ready_o, mem_ready_o}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_master", {63'd0, mem_ready_o}, {63'd0, e.m});
        check("resp_data", e.m ? mem_data_o : if_data_o, e.d);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Waits for a grant, checks the latched fields, answers after dly cycles, checks RESP.
  task automatic serve(input bit m, input bit we, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [7:0] sz, input int dly,
                       input logic [63:0] rd, input bit hold, input bit perturb,
                       output int waited);
    waited = 0;
    while (!rw_valid_o && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("grant_seen", {63'd0, rw_valid_o}, 64'd1);
    check("rw_we", {63'd0, rw_we_o}, {63'd0, we});
    check("rw_addr", {32'd0, rw_addr_o}, {32'd0, addr});
    check("rw_wdata", rw_w_data_o, wd);
    check("rw_size", {56'd0, rw_size_o}, {56'd0, sz});
    if (perturb) begin
      mem_we_i    = ~mem_we_i;
      mem_addr_i  = 32'h0BAD_0000;
      mem_wdata_i = 64'hFFFF_0000_FFFF_0000;
      mem_strb_i  = 8'hA5;
    end
    repeat (dly) begin
      @(negedge clock);
      check("hold_valid", {63'd0, rw_valid_o}, 64'd1);
      check("hold_addr", {32'd0, rw_addr_o}, {32'd0, addr});
      check("hold_we_size", {55'd0, rw_we_o, rw_size_o}, {55'd0, we, sz});
      check("hold_wdata", rw_w_data_o, wd);
    end
    rw_ready_i = 1'b1;
    rw_data_i  = rd;
    sb.push_back('{m: m, d: rd});
    @(negedge clock);
    rw_ready_i = 1'b0;
    rw_data_i  = 64'h5A5A_5A5A_5A5A_5A5A;
    check("resp_valid_low", {63'd0, rw_valid_o}, 64'd0);
    check("resp_ready", {62'd0, if_ready_o, mem_ready_o}, m ? 64'd1 : 64'd2);
    if (!hold) begin
      if (m) mem_valid_i = 1'b0;
      else   if_valid_i  = 1'b0;
    end
  endtask

  initial begin
    int w;
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    // Reset state
    @(negedge clock);
    check("rst_valid", {63'd0, rw_valid_o}, 64'd0);
    check("rst_ready", {62'd0, if_ready_o, mem_ready_o}, 64'd0);
    check("rst_fields", {rw_we_o, rw_addr_o, rw_size_o}, 64'd0);
    check("rst_data", if_data_o | mem_data_o | rw_w_data_o, 64'd0);
    reset = 1'b1;

    // Single IF read
    @(negedge clock);
    if_addr_i  = 32'h8000_0000;
    if_valid_i = 1'b1;
    serve(1'b0, 1'b0, 32'h8000_0000, 64'd0, 8'hFF, 3, 64'hDEAD_BEEF_0000_0013, 1'b0, 1'b0, w);
    check("if_first_latency", w, 1);
    @(negedge clock);
    check("if_data_held", if_data_o, 64'hDEAD_BEEF_0000_0013);
    check("if_no_mem_ready", mem_pulses, 0);

    // MEM write with inputs perturbed during the grant
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h8000_1000;
    mem_wdata_i = 64'h1122_3344_5566_7788;
    mem_strb_i  = 8'h0F;
    mem_valid_i = 1'b1;
    serve(1'b1, 1'b1, 32'h8000_1000, 64'h1122_3344_5566_7788, 8'h0F, 2,
          64'h0000_0000_CAFE_0001, 1'b0, 1'b1, w);
    @(negedge clock);
    check("mem_data_held", mem_data_o, 64'h0000_0000_CAFE_0001);

    // Both valid from reset: MEM, IF, MEM, IF with 2-cycle gaps
    do_reset();
    if_addr_i   = 32'h8000_0100;
    mem_we_i    = 1'b0;
    mem_addr_i  = 32'h8000_2000;
    mem_wdata_i = 64'h0;
    mem_strb_i  = 8'h33;
    if_valid_i  = 1'b1;
    mem_valid_i = 1'b1;
    serve(1'b1, 1'b0, 32'h8000_2000, 64'd0, 8'h33, 1, 64'h1111, 1'b1, 1'b0, w);
    check("tie1_wait", w, 1);
    serve(1'b0, 1'b0, 32'h8000_0100, 64'd0, 8'hFF, 0, 64'h2222, 1'b1, 1'b0, w);
    check("tie2_gap", w, 2);
    serve(1'b1, 1'b0, 32'h8000_2000, 64'd0, 8'h33, 2, 64'h3333, 1'b1, 1'b0, w);
    check("tie3_gap", w, 2);
    serve(1'b0, 1'b0, 32'h8000_0100, 64'd0, 8'hFF, 1, 64'h4444, 1'b1, 1'b0, w);
    check("tie4_gap", w, 2);
    if_valid_i  = 1'b0;
    mem_valid_i = 1'b0;
    repeat (2) @(negedge clock);
    check("tie_idle", {63'd0, rw_valid_o}, 64'd0);

    // IF holds valid through RESP: regrant only after the IDLE cycle
    if_addr_i  = 32'h8000_0200;
    if_valid_i = 1'b1;
    serve(1'b0, 1'b0, 32'h8000_0200, 64'd0, 8'hFF, 0, 64'h5555, 1'b1, 1'b0, w);
    @(negedge clock);
    check("hold_resp_idle", {63'd0, rw_valid_o}, 64'd0);
    serve(1'b0, 1'b0, 32'h8000_0200, 64'd0, 8'hFF, 1, 64'h6666, 1'b0, 1'b0, w);
    check("hold_regrant_wait", w, 1);
    @(negedge clock);

    // rw_ready_i while IDLE is ignored
    rw_ready_i = 1'b1;
    rw_data_i  = 64'h7777;
    @(negedge clock);
    rw_ready_i = 1'b0;
    check("idle_rdy_valid", {63'd0, rw_valid_o}, 64'd0);
    check("idle_rdy_ready", {62'd0, if_ready_o, mem_ready_o}, 64'd0);
    @(negedge clock);
    check("idle_rdy_later", {62'd0, if_ready_o, mem_ready_o}, 64'd0);
    check("idle_rdy_data", if_data_o, 64'h6666);

    // Reset mid GNT_MEM, bridge never answers; IF pending then served
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h8000_3000;
    mem_wdata_i = 64'hABCD;
    mem_strb_i  = 8'hF0;
    mem_valid_i = 1'b1;
    w = 0;
    while (!rw_valid_o && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("rst_mid_granted", {rw_valid_o, rw_we_o, rw_addr_o}, {1'b1, 1'b1, 32'h8000_3000});
    if_addr_i  = 32'h8000_0400;
    if_valid_i = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_valid", {63'd0, rw_valid_o}, 64'd0);
    check("rst_mid_ready", {62'd0, if_ready_o, mem_ready_o}, 64'd0);
    check("rst_mid_data", if_data_o | mem_data_o, 64'd0);
    check("rst_mid_fields", {rw_we_o, rw_addr_o, rw_size_o}, 64'd0);
    @(negedge clock);
    mem_valid_i = 1'b0;
    reset = 1'b1;
    serve(1'b0, 1'b0, 32'h8000_0400, 64'd0, 8'hFF, 1, 64'h8888, 1'b0, 1'b0, w);
    check("post_rst_wait", w, 1);
    repeat (3) @(negedge clock);

    check("sb_empty", sb.size(), 0);
    check("if_pulse_total", if_pulses, 6);
    check("mem_pulse_total", mem_pulses, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
